// File: rtl/ex_hilo_pkg.sv
// Shared op codes, FSM encoding and op classification helpers for the HI/LO unit.
package ex_hilo_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_mc(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_MSUBU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   // Codes 11..15 behave as NOP and never request a HI/LO write.
   function automatic logic is_active(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_MTLO);
   endfunction

endpackage

// File: rtl/ex_hilo_if.sv
// Issue-bundle and HI/LO result bus between the execute stage and the HI/LO unit.
interface ex_hilo_if #(
   parameter int LANES = 2,
   parameter int XLEN  = 32
);
   logic                    flush;
   logic [LANES-1:0]        lane_valid;
   logic [4*LANES-1:0]      lane_op;
   logic [XLEN*LANES-1:0]   lane_opa;
   logic [XLEN*LANES-1:0]   lane_opb;
   logic [XLEN-1:0]         hi_i;
   logic [XLEN-1:0]         lo_i;
   logic                    stallreq;
   logic                    whilo_o;
   logic [XLEN-1:0]         hi_o;
   logic [XLEN-1:0]         lo_o;
   logic                    busy_o;

   modport master (
      output flush, lane_valid, lane_op, lane_opa, lane_opb, hi_i, lo_i,
      input  stallreq, whilo_o, hi_o, lo_o, busy_o
   );

   modport slave (
      input  flush, lane_valid, lane_op, lane_opa, lane_opb, hi_i, lo_i,
      output stallreq, whilo_o, hi_o, lo_o, busy_o
   );
endinterface

// File: rtl/ex_hilo_div.sv
// Iterative radix-2 restoring divider on magnitudes with sign fixup; divide-by-zero resolves in one cycle.
module ex_hilo_div #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            sign,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quot,
   output logic [XLEN-1:0] rem
);
   localparam int DW = $clog2(XLEN);

   logic            run_reg, dz_reg, neg_q_reg, neg_r_reg;
   logic [DW-1:0]   cnt_reg;
   logic [XLEN-1:0] dvs_reg, quo_reg, rem_reg, dvd_reg;

   logic [XLEN-1:0] dvd_mag, dvs_mag, step_quo, step_rem;
   logic [XLEN:0]   rem_sh, diff;
   logic            q_bit;

   assign dvd_mag = (sign && dividend[XLEN-1]) ? -dividend : dividend;
   assign dvs_mag = (sign && divisor[XLEN-1])  ? -divisor  : divisor;

   assign rem_sh   = {rem_reg, quo_reg[XLEN-1]};
   assign diff     = rem_sh - {1'b0, dvs_reg};
   assign q_bit    = ~diff[XLEN];
   assign step_rem = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign step_quo = {quo_reg[XLEN-2:0], q_bit};

   // The final iteration is consumed combinationally so the caller can retire in that same cycle.
   assign done = run_reg && (dz_reg || (cnt_reg == DW'(XLEN-1)));
   assign quot = dz_reg ? '1 : (neg_q_reg ? -step_quo : step_quo);
   assign rem  = dz_reg ? dvd_reg : (neg_r_reg ? -step_rem : step_rem);

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         run_reg <= 1'b0;
         cnt_reg <= '0;
      end else if (start) begin
         run_reg   <= 1'b1;
         dz_reg    <= (divisor == '0);
         cnt_reg   <= '0;
         neg_q_reg <= sign && (dividend[XLEN-1] ^ divisor[XLEN-1]);
         neg_r_reg <= sign && dividend[XLEN-1];
         dvs_reg   <= dvs_mag;
         quo_reg   <= dvd_mag;
         rem_reg   <= '0;
         dvd_reg   <= dividend;
      end else if (run_reg) begin
         quo_reg <= step_quo;
         rem_reg <= step_rem;
         cnt_reg <= cnt_reg + 1'b1;
         if (done)
            run_reg <= 1'b0;
      end
   end
endmodule

// File: rtl/ex_hilo_unit.sv
// Sequenced HI/LO unit: applies a bundle's ops in lane order on a shadow HI/LO, stalling for mul/div.
module ex_hilo_unit
   import ex_hilo_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
) (
   input  logic      clk,
   input  logic      rst,
   ex_hilo_if.slave  bus
);
   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   logic [3:0]      op_arr  [LANES];
   logic [XLEN-1:0] opa_arr [LANES];
   logic [XLEN-1:0] opb_arr [LANES];
   logic [LANES-1:0] lane_act;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign op_arr[gi]   = bus.lane_op[4*gi +: 4];
         assign opa_arr[gi]  = bus.lane_opa[XLEN*gi +: XLEN];
         assign opb_arr[gi]  = bus.lane_opb[XLEN*gi +: XLEN];
         assign lane_act[gi] = bus.lane_valid[gi] && is_active(op_arr[gi]);
      end
   endgenerate

   state_t          state_reg;
   logic [PW-1:0]   ptr_reg;
   logic [CW-1:0]   mul_cnt_reg;
   logic [XLEN-1:0] sh_hi_reg, sh_lo_reg;

   logic kill, in_idle, mul_last, div_done, op_done, launch;
   assign kill     = rst || bus.flush;
   assign in_idle  = (state_reg == ST_IDLE);
   assign mul_last = (state_reg == ST_MUL) && (mul_cnt_reg == CW'(MUL_LAT-1));
   assign op_done  = mul_last || ((state_reg == ST_DIV) && div_done);

   // Result of the MC op at ptr_reg, valid in its final cycle.
   logic [3:0]        cur_op;
   logic [2*XLEN-1:0] acc, res;
   logic [2*XLEN-1:0] mul_pipe [MUL_LAT];
   logic [XLEN-1:0]   div_quot, div_rem;

   assign cur_op = op_arr[ptr_reg];
   assign acc    = {sh_hi_reg, sh_lo_reg};

   always_comb begin
      res = acc;
      case (cur_op)
         OP_MULT, OP_MULTU: res = mul_pipe[MUL_LAT-1];
         OP_MADD, OP_MADDU: res = acc + mul_pipe[MUL_LAT-1];
         OP_MSUB, OP_MSUBU: res = acc - mul_pipe[MUL_LAT-1];
         OP_DIV,  OP_DIVU:  res = {div_rem, div_quot};
         default:           res = acc;
      endcase
   end

   // Walk lanes from scan_from applying MTHI/MTLO until the next valid MC lane.
   logic [PW:0]     scan_from;
   logic [XLEN-1:0] scan_hi_in, scan_lo_in, scan_hi, scan_lo;
   logic            scan_found;
   logic [PW-1:0]   scan_idx;

   assign scan_from  = in_idle ? '0 : ({1'b0, ptr_reg} + 1'b1);
   assign scan_hi_in = in_idle ? bus.hi_i : res[2*XLEN-1:XLEN];
   assign scan_lo_in = in_idle ? bus.lo_i : res[XLEN-1:0];

   always_comb begin
      scan_hi    = scan_hi_in;
      scan_lo    = scan_lo_in;
      scan_found = 1'b0;
      scan_idx   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (((PW+1)'(i) >= scan_from) && !scan_found && bus.lane_valid[i]) begin
            if (is_mc(op_arr[i])) begin
               scan_found = 1'b1;
               scan_idx   = PW'(i);
            end else if (op_arr[i] == OP_MTHI) begin
               scan_hi = opa_arr[i];
            end else if (op_arr[i] == OP_MTLO) begin
               scan_lo = opa_arr[i];
            end
         end
      end
   end

   assign launch = !kill && scan_found && (in_idle || op_done);

   // Multiplier feeds from the lane being launched so stage MUL_LAT-1 is ready in the last MUL cycle.
   logic [PW-1:0]     mul_idx;
   logic [XLEN-1:0]   mul_opa, mul_opb;
   logic              mul_sgn;
   logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;

   assign mul_idx  = launch ? scan_idx : ptr_reg;
   assign mul_opa  = opa_arr[mul_idx];
   assign mul_opb  = opb_arr[mul_idx];
   assign mul_sgn  = is_signed_op(op_arr[mul_idx]);
   assign mul_a    = {{XLEN{mul_sgn & mul_opa[XLEN-1]}}, mul_opa};
   assign mul_b    = {{XLEN{mul_sgn & mul_opb[XLEN-1]}}, mul_opb};
   assign mul_prod = mul_a * mul_b;

   generate
      for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_mul
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) mul_pipe[0] <= mul_prod;
         end else begin : g_next
            always_ff @(posedge clk) mul_pipe[gi] <= mul_pipe[gi-1];
         end
      end
   endgenerate

   logic [3:0] launch_op;
   assign launch_op = op_arr[scan_idx];

   ex_hilo_div #(.XLEN(XLEN)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (launch && is_div(launch_op)),
      .abort    (bus.flush),
      .sign     (launch_op == OP_DIV),
      .dividend (opa_arr[scan_idx]),
      .divisor  (opb_arr[scan_idx]),
      .done     (div_done),
      .quot     (div_quot),
      .rem      (div_rem)
   );

   always_ff @(posedge clk) begin
      if (kill) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= '0;
         mul_cnt_reg <= '0;
         sh_hi_reg   <= '0;
         sh_lo_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_MUL, ST_DIV: begin
               if ((state_reg == ST_MUL) && !mul_last)
                  mul_cnt_reg <= mul_cnt_reg + 1'b1;
               if (launch) begin
                  sh_hi_reg   <= scan_hi;
                  sh_lo_reg   <= scan_lo;
                  ptr_reg     <= scan_idx;
                  mul_cnt_reg <= '0;
                  state_reg   <= is_div(launch_op) ? ST_DIV : ST_MUL;
               end else if (op_done) begin
                  sh_hi_reg <= scan_hi;
                  sh_lo_reg <= scan_lo;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   logic idle_we;
   assign idle_we = in_idle && !kill && !scan_found && (|lane_act);

   assign bus.stallreq = (in_idle && scan_found) || (state_reg == ST_MUL) || (state_reg == ST_DIV);
   assign bus.busy_o   = !in_idle;
   assign bus.whilo_o  = ((state_reg == ST_DONE) && !kill) || idle_we;
   assign bus.hi_o     = ((state_reg == ST_DONE) && !kill) ? sh_hi_reg : (idle_we ? scan_hi : '0);
   assign bus.lo_o     = ((state_reg == ST_DONE) && !kill) ? sh_lo_reg : (idle_we ? scan_lo : '0);
endmodule

// File: tb/tb_ex_hilo_unit.sv
// Randomized and directed bundles for ex_hilo_unit checked against a plain-arithmetic bundle model.
module tb_ex_hilo_unit;
   localparam int LANES   = 2;
   localparam int XLEN    = 32;
   localparam int MUL_LAT = 2;

   logic clk;
   logic rst;

   ex_hilo_if #(.LANES(LANES), .XLEN(XLEN)) bus ();

   ex_hilo_unit #(.LANES(LANES), .XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   bit          b_v   [LANES];
   logic [3:0]  b_op  [LANES];
   logic [31:0] b_a   [LANES];
   logic [31:0] b_b   [LANES];
   logic [31:0] b_hi, b_lo;

   logic [31:0] got_hi, got_lo;
   int          got_stall;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_lane(input int i, input bit v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
      b_v[i] = v; b_op[i] = op; b_a[i] = a; b_b[i] = b;
   endtask

   task automatic drive_bundle();
      for (int i = 0; i < LANES; i++) begin
         bus.lane_valid[i]        = b_v[i];
         bus.lane_op[4*i +: 4]    = b_op[i];
         bus.lane_opa[32*i +: 32] = b_a[i];
         bus.lane_opb[32*i +: 32] = b_b[i];
      end
      bus.hi_i = b_hi;
      bus.lo_i = b_lo;
   endtask

   // Whole-bundle effect computed with ordinary integer arithmetic, lane by lane.
   task automatic model(output logic [31:0] ehi, output logic [31:0] elo,
                        output int estall, output bit ewe, output bit emc);
      logic [31:0] h, l;
      logic [63:0] acc, p;
      logic signed [63:0] sa, sb, sq, sr;
      int cyc;
      bit any_op;
      h = b_hi; l = b_lo; cyc = 0; any_op = 0; emc = 0;
      for (int i = 0; i < LANES; i++) begin
         if (b_v[i]) begin
            if (b_op[i] >= 1 && b_op[i] <= 10) any_op = 1;
            case (b_op[i])
               4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: begin
                  emc = 1;
                  cyc += MUL_LAT;
                  if (b_op[i] == 1 || b_op[i] == 5 || b_op[i] == 7) begin
                     sa = $signed(b_a[i]); sb = $signed(b_b[i]);
                     p  = sa * sb;
                  end else begin
                     p = {32'b0, b_a[i]} * {32'b0, b_b[i]};
                  end
                  acc = {h, l};
                  if (b_op[i] <= 2)      acc = p;
                  else if (b_op[i] <= 6) acc = acc + p;
                  else                   acc = acc - p;
                  h = acc[63:32]; l = acc[31:0];
               end
               4'd3, 4'd4: begin
                  emc = 1;
                  if (b_b[i] == 0) begin
                     cyc += 1;
                     l = 32'hFFFF_FFFF; h = b_a[i];
                  end else begin
                     cyc += XLEN;
                     if (b_op[i] == 3) begin
                        sa = $signed(b_a[i]); sb = $signed(b_b[i]);
                        sq = sa / sb; sr = sa % sb;
                        l = sq[31:0]; h = sr[31:0];
                     end else begin
                        l = b_a[i] / b_b[i]; h = b_a[i] % b_b[i];
                     end
                  end
               end
               4'd9:    h = b_a[i];
               4'd10:   l = b_a[i];
               default: ;
            endcase
         end
      end
      estall = emc ? cyc + 1 : 0;
      ewe    = any_op;
      ehi    = ewe ? h : 32'h0;
      elo    = ewe ? l : 32'h0;
   endtask

   task automatic run_bundle(input string tag);
      logic [31:0] ehi, elo;
      int  estall, stalls;
      bit  ewe, emc, done;
      model(ehi, elo, estall, ewe, emc);
      @(posedge clk); #1;
      drive_bundle();
      stalls = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         #3;
         if (bus.stallreq) begin
            chk({tag, "_we_in_stall"}, 64'(bus.whilo_o), 64'h0);
            stalls++;
            @(posedge clk); #1;
         end else begin
            done = 1;
         end
      end
      if (!done) chk({tag, "_timeout"}, 64'h0, 64'h1);
      got_stall = stalls; got_hi = bus.hi_o; got_lo = bus.lo_o;
      chk({tag, "_stall"}, 64'(stalls), 64'(estall));
      chk({tag, "_we"},    64'(bus.whilo_o), 64'(ewe));
      chk({tag, "_busy"},  64'(bus.busy_o), 64'(emc));
      chk({tag, "_hi"},    64'(bus.hi_o), 64'(ehi));
      chk({tag, "_lo"},    64'(bus.lo_o), 64'(elo));
      $display("bundle %s: stall=%0d we=%0b hi=%h lo=%h", tag, stalls, bus.whilo_o, bus.hi_o, bus.lo_o);
      @(posedge clk); #1;
      bus.lane_valid = '0;
      #3;
      chk({tag, "_after_we"},   64'(bus.whilo_o), 64'h0);
      chk({tag, "_after_busy"}, 64'(bus.busy_o), 64'h0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.lane_valid = '0;
      bus.lane_op = '0;
      bus.lane_opa = '0;
      bus.lane_opb = '0;
      bus.hi_i = '0;
      bus.lo_i = '0;
      for (int i = 0; i < LANES; i++) set_lane(i, 0, 4'd0, 32'h0, 32'h0);
      b_hi = 0; b_lo = 0;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_busy",  64'(bus.busy_o),   64'h0);
      chk("rst_we",    64'(bus.whilo_o),  64'h0);
      chk("rst_stall", 64'(bus.stallreq), 64'h0);
      chk("rst_hi",    64'(bus.hi_o),     64'h0);
      chk("rst_lo",    64'(bus.lo_o),     64'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      set_lane(0, 1, 4'd2, 32'hFFFF_FFFF, 32'h2); set_lane(1, 0, 4'd0, 0, 0);
      run_bundle("d_multu");
      chk("d_multu_stall_k", 64'(got_stall), 64'd3);
      chk("d_multu_hi_k", 64'(got_hi), 64'h1);
      chk("d_multu_lo_k", 64'(got_lo), 64'hFFFF_FFFE);

      set_lane(0, 1, 4'd3, 32'd7, 32'hFFFF_FFFE);
      run_bundle("d_div");
      chk("d_div_stall_k", 64'(got_stall), 64'd33);
      chk("d_div_lo_k", 64'(got_lo), 64'hFFFF_FFFD);
      chk("d_div_hi_k", 64'(got_hi), 64'h1);

      set_lane(0, 1, 4'd2, 32'd3, 32'd4); set_lane(1, 1, 4'd6, 32'd5, 32'd6);
      run_bundle("d_maddu");
      chk("d_maddu_stall_k", 64'(got_stall), 64'd5);
      chk("d_maddu_lo_k", 64'(got_lo), 64'h2A);

      set_lane(0, 1, 4'd9, 32'h1234, 0); set_lane(1, 1, 4'd10, 32'h5678, 0);
      run_bundle("d_mthilo");
      chk("d_mthilo_hi_k", 64'(got_hi), 64'h1234);
      chk("d_mthilo_lo_k", 64'(got_lo), 64'h5678);

      set_lane(0, 1, 4'd4, 32'd9, 32'd0); set_lane(1, 1, 4'd9, 32'hAA, 0);
      run_bundle("d_divz");
      chk("d_divz_stall_k", 64'(got_stall), 64'd2);
      chk("d_divz_lo_k", 64'(got_lo), 64'hFFFF_FFFF);
      chk("d_divz_hi_k", 64'(got_hi), 64'hAA);

      set_lane(0, 1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF); set_lane(1, 0, 4'd0, 0, 0);
      run_bundle("d_divovf");
      chk("d_divovf_lo_k", 64'(got_lo), 64'h8000_0000);
      chk("d_divovf_hi_k", 64'(got_hi), 64'h0);

      // Flush in IDLE must swallow a zero-cycle write.
      set_lane(0, 1, 4'd9, 32'h55, 0);
      @(posedge clk); #1;
      drive_bundle();
      bus.flush = 1'b1;
      #3;
      chk("flush_idle_we", 64'(bus.whilo_o), 64'h0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.lane_valid = '0;

      // Flush ten cycles into a divide.
      set_lane(0, 1, 4'd3, 32'd100, 32'd7);
      @(posedge clk); #1;
      drive_bundle();
      for (int c = 0; c < 10; c++) begin
         #3;
         chk("flush_div_stall", 64'(bus.stallreq), 64'h1);
         @(posedge clk); #1;
      end
      bus.flush = 1'b1;
      #3;
      chk("flush_cycle_we", 64'(bus.whilo_o), 64'h0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.lane_valid = '0;
      #3;
      chk("flush_next_stall", 64'(bus.stallreq), 64'h0);
      chk("flush_next_busy",  64'(bus.busy_o),   64'h0);
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #4;
         chk("flush_quiet_we", 64'(bus.whilo_o), 64'h0);
      end
      set_lane(0, 1, 4'd1, 32'hFFFF_FFFD, 32'd7);
      run_bundle("flush_then_mult");

      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < LANES; i++)
            set_lane(i, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), pick_val(), pick_val());
         b_hi = $urandom;
         b_lo = $urandom;
         run_bundle($sformatf("rnd%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_hilo_unit.md
# ex_hilo_unit

Parametrised HI/LO arithmetic unit for the N-lane execute stage. It accepts one issue bundle of up to LANES operations that target HI/LO: multiply, divide, multiply-accumulate and MTHI/MTLO. Multi-cycle operations run serially in lane (program) order on a pipelined multiplier and an iterative divider, and the unit raises `stallreq` until the whole bundle has resolved. It replaces the fixed two-lane HI/LO merge and the external mul/div ready handshake with a single sequenced unit that writes back one merged HI/LO result per bundle.

## Interface
Reset rst: synchronous, active-high.

Parameters:
- `LANES`, default 2: number of issue lanes.
- `XLEN`, default 32: operand and HI/LO width.
- `MUL_LAT`, default 2: multiplier pipeline depth in cycles, must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `flush` in 1: synchronous cancel of the current bundle.
- `lane_valid` in LANES: lane holds a HI/LO op.
- `lane_op` in 4*LANES: op code per lane, lane i at [4i+3:4i].
- `lane_opa` in XLEN*LANES: rs operand per lane.
- `lane_opb` in XLEN*LANES: rt operand per lane.
- `hi_i` in XLEN: current HI, already forwarded from later stages.
- `lo_i` in XLEN: current LO, already forwarded from later stages.
- `stallreq` out 1: hold the bundle; combinational.
- `whilo_o` out 1: HI/LO write enable.
- `hi_o` out XLEN: merged HI result.
- `lo_o` out XLEN: merged LO result.
- `busy_o` out 1: the state machine is not in IDLE.

## Operation
- Op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10. Codes 11–15 are treated as NOP.
- Multi-cycle ops (MC) are MULT through MSUBU. MTHI/MTLO are zero-cycle ops.
- Shadow registers `sh_hi`/`sh_lo` are loaded from `hi_i`/`lo_i` when a bundle is accepted. Ops apply to the shadow in ascending lane order, so each lane sees the results of the lanes before it.
  - MTHI writes `sh_hi`; MTLO writes `sh_lo`.
  - MULT/MULTU write the full 2·XLEN product to {hi,lo}.
  - MADD/MSUB add or subtract the product to/from {sh_hi,sh_lo}, modulo 2^(2·XLEN).
- Signed ops use the two's-complement interpretation; the U variants are unsigned.
- DIV/DIVU: lo=quotient, hi=remainder, truncating division, remainder takes the sign of the dividend.
  - Divisor 0: lo=all ones, hi=dividend, and the divide takes 1 cycle.
  - Signed -2^(XLEN-1)/-1: lo=0x80000000, hi=0 (XLEN=32).
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - Bundle with no valid MC lane: apply all ops combinationally; `whilo_o`=1 if any lane is valid and non-NOP; `stallreq`=0; remain in IDLE.
  - Bundle with at least one MC lane: `stallreq`=1; latch the shadow and the lane pointer at the first MC lane, applying earlier zero-cycle lanes first; go to MUL or DIV.
- MUL: counter runs MUL_LAT cycles. On the last cycle, write the product/accumulate to the shadow.
- DIV: radix-2 restoring iteration, XLEN cycles (1 cycle if divisor is 0). On the last cycle, write quotient/remainder to the shadow.
- On MUL/DIV completion:
  - Apply the zero-cycle lanes that follow.
  - If a later MC lane exists, enter MUL/DIV for it directly, with no DONE in between.
  - Otherwise go to DONE.
- DONE: `stallreq`=0, `whilo_o`=1, `hi_o`/`lo_o`=shadow; next state IDLE. The pipeline advances this cycle, so the bundle is never re-accepted.
- `stallreq` is 1 in IDLE with an MC bundle, in MUL and in DIV; 0 otherwise.
- `flush` (any state): next state IDLE, shadow discarded, no `whilo_o` for the cancelled bundle. `flush` in IDLE suppresses `whilo_o` that cycle.
- `rst`: identical to `flush`.
- Upstream holds the `lane_*` inputs stable while `stallreq`=1.

## Timing
- Reset values: FSM=IDLE, `busy_o`=0, `whilo_o`=0, `hi_o`=`lo_o`=0, `stallreq`=0 (with `lane_valid`=0).
- Bundle first seen at t0.
  - Single MUL: stall t0..t0+MUL_LAT, DONE at t0+MUL_LAT+1.
  - Single DIV: stall XLEN+1 cycles, DONE at t0+XLEN+1.
- k serial MC ops: stall = 1 + Σ(op cycles).
- `whilo_o`/`hi_o`/`lo_o` are valid only in the DONE cycle, or in the IDLE cycle of a zero-cycle bundle. Outside those cycles they are 0.

## Structure
- Package `ex_hilo_pkg`: op-code localparams, an `is_mc(op)` function, and FSM state encoding.
- Sub-module `ex_hilo_div`: iterative XLEN-bit divider with start/done, a sign-fixup stage and the divide-by-zero shortcut.
- The multiplier is an inline MUL_LAT-stage register chain of the XLEN×XLEN product.

## Test plan
- MUL_LAT=2, lane0 MULTU 0xFFFFFFFF×2 → stall 3 cycles, then `whilo_o`=1, hi=0x00000001, lo=0xFFFFFFFE.
- Lane0 DIV 7/−2 → stall 33 cycles, then lo=0xFFFFFFFD, hi=0x00000001.
- Lane0 MULTU 3×4, lane1 MADDU 5×6, with hi_i=lo_i=0 → stall 5 cycles, then hi=0, lo=42 (0x2A).
- Lane0 MTHI 0x1234, lane1 MTLO 0x5678 → no stall, `whilo_o`=1 the same cycle, hi=0x1234, lo=0x5678.
- Lane0 DIVU 9/0, lane1 MTHI 0xAA → stall 2 cycles, then lo=0xFFFFFFFF, hi=0xAA.
- DIV started, `flush` at cycle 10 → `stallreq`=0 and `busy_o`=0 the next cycle, `whilo_o` never asserted; a following MULT bundle then completes normally.
